// File: rtl/miriscv_fetch_pkg.sv
// Types and defaults for the fetch-to-decode instruction queue.
package miriscv_fetch_pkg;

  localparam int unsigned FETCH_Q_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [miriscv_pkg::ILEN-1:0] instr;
    logic [miriscv_pkg::XLEN-1:0] current_pc;
    logic [miriscv_pkg::XLEN-1:0] next_pc;
  } fetch_entry_t;

endpackage

// File: rtl/miriscv_pkg.sv
// Core-wide architectural widths shared by the miriscv pipeline stages.
package miriscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

endpackage

// File: rtl/miriscv_fetch_queue_chk.sv
// Simulation-only protocol checks for miriscv_fetch_queue.
module miriscv_fetch_queue_chk #(
  parameter int unsigned DEPTH  = 4,
  parameter logic        BYPASS = 1'b1,
  parameter int unsigned CW     = 3
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (count == DEPTH_C)));

  no_pop_when_empty : assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop && (count == ZERO_C) && !BYPASS));

  depth_pow2 : assert property (@(posedge clk_i)
    ((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= 2));

endmodule

// File: rtl/miriscv_fetch_queue.sv
// Fetch-to-decode instruction queue with optional same-cycle bypass when empty.
module miriscv_fetch_queue
  import miriscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = FETCH_Q_DEPTH_DEFAULT,
  parameter logic        BYPASS = 1'b1,
  parameter int unsigned XLEN   = miriscv_pkg::XLEN,
  parameter int unsigned ILEN   = miriscv_pkg::ILEN
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       f_valid_i,
  input  logic [ILEN-1:0]            f_instr_i,
  input  logic [XLEN-1:0]            f_current_pc_i,
  input  logic [XLEN-1:0]            f_next_pc_i,
  output logic                       f_ready_o,
  output logic                       d_valid_o,
  output logic [ILEN-1:0]            d_instr_o,
  output logic [XLEN-1:0]            d_current_pc_o,
  output logic [XLEN-1:0]            d_next_pc_o,
  input  logic                       d_ready_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       almost_full_o
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [PW-1:0] PTR_ZERO_C = {PW{1'b0}};

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  fetch_entry_t  in_s;
  fetch_entry_t  head_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          bypass_s;
  logic          wr_en_s;
  logic          rd_adv_s;

  assign in_s      = '{instr: f_instr_i, current_pc: f_current_pc_i, next_pc: f_next_pc_i};
  assign empty_s   = (count_r == ZERO_C);
  assign f_ready_o = (count_r != DEPTH_C);
  assign push_s    = f_valid_i & f_ready_o;

  // Head selection: stored entry, bypassed fetch entry, or idle zeros.
  always_comb begin
    head_s    = '{default: 1'b0};
    d_valid_o = 1'b0;
    if (!empty_s) begin
      head_s    = mem_r[rd_ptr_r];
      d_valid_o = 1'b1;
    end else if (BYPASS) begin
      head_s    = in_s;
      d_valid_o = f_valid_i;
    end else begin
      head_s    = '{default: 1'b0};
      d_valid_o = 1'b0;
    end
  end

  assign d_instr_o      = head_s.instr;
  assign d_current_pc_o = head_s.current_pc;
  assign d_next_pc_o    = head_s.next_pc;

  // An entry consumed straight through the bypass never touches storage.
  assign pop_s    = d_valid_o & d_ready_i;
  assign bypass_s = BYPASS & empty_s & push_s & pop_s;
  assign wr_en_s  = push_s & ~bypass_s & ~flush_i;
  assign rd_adv_s = pop_s & ~empty_s;

  // Pointer and occupancy state; flush collapses the queue onto the write pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_r <= PTR_ZERO_C;
      wr_ptr_r <= PTR_ZERO_C;
      count_r  <= ZERO_C;
    end else if (flush_i) begin
      rd_ptr_r <= wr_ptr_r;
      count_r  <= ZERO_C;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (rd_adv_s) rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      count_r <= count_r + CW'(wr_en_s) - CW'(rd_adv_s);
    end
  end

  // Entry storage, intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= in_s;
  end

  assign count_o       = count_r;
  assign almost_full_o = (count_r >= AF_C);

  miriscv_fetch_queue_chk #(
    .DEPTH  (DEPTH),
    .BYPASS (BYPASS),
    .CW     (CW)
  ) u_chk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push   (push_s),
    .pop    (pop_s),
    .count  (count_r)
  );

endmodule

// File: tb/tb_miriscv_fetch_queue.sv
// Bench for miriscv_fetch_queue: BYPASS=1 and BYPASS=0 instances share stimulus, checked against a queue model.
module tb_miriscv_fetch_queue;
  import miriscv_fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int XL    = miriscv_pkg::XLEN;
  localparam int IL    = miriscv_pkg::ILEN;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_valid = 1'b0;
  logic          d_ready = 1'b0;
  logic          flush = 1'b0;
  logic [IL-1:0] f_instr = '0;
  logic [XL-1:0] f_pc = '0;
  logic [XL-1:0] f_npc = '0;

  logic          b_f_ready, b_d_valid, b_af;
  logic [IL-1:0] b_instr;
  logic [XL-1:0] b_pc, b_npc;
  logic [CW-1:0] b_count;
  logic          r_f_ready, r_d_valid, r_af;
  logic [IL-1:0] r_instr;
  logic [XL-1:0] r_pc, r_npc;
  logic [CW-1:0] r_count;

  int tests = 0;
  int fails = 0;
  bit model_ok = 1'b0;
  fetch_entry_t qb[$];
  fetch_entry_t qr[$];
  logic [XL-1:0] popped[$];

  always #5 clk = ~clk;

  miriscv_fetch_queue #(.DEPTH(DEPTH), .BYPASS(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .f_valid_i(f_valid), .f_instr_i(f_instr),
    .f_current_pc_i(f_pc), .f_next_pc_i(f_npc), .f_ready_o(b_f_ready),
    .d_valid_o(b_d_valid), .d_instr_o(b_instr), .d_current_pc_o(b_pc),
    .d_next_pc_o(b_npc), .d_ready_i(d_ready), .flush_i(flush),
    .count_o(b_count), .almost_full_o(b_af)
  );

  miriscv_fetch_queue #(.DEPTH(DEPTH), .BYPASS(1'b0)) dut_r (
    .clk_i(clk), .rst_i(rst), .f_valid_i(f_valid), .f_instr_i(f_instr),
    .f_current_pc_i(f_pc), .f_next_pc_i(f_npc), .f_ready_o(r_f_ready),
    .d_valid_o(r_d_valid), .d_instr_o(r_instr), .d_current_pc_o(r_pc),
    .d_next_pc_o(r_npc), .d_ready_i(d_ready), .flush_i(flush),
    .count_o(r_count), .almost_full_o(r_af)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // What decode should see given the queued entries and the current fetch offer.
  function automatic void model_out(input bit byp, input fetch_entry_t q[$], input fetch_entry_t fin,
                                    output bit v, output fetch_entry_t d);
    if (q.size() > 0) begin
      v = 1'b1; d = q[0];
    end else if (byp) begin
      v = f_valid; d = fin;
    end else begin
      v = 1'b0; d = '0;
    end
  endfunction

  function automatic void model_step(input bit byp, input fetch_entry_t qi[$], input fetch_entry_t fin,
                                     output fetch_entry_t qo[$]);
    bit v, push, pop;
    fetch_entry_t d;
    qo = qi;
    if (rst || flush) begin
      qo.delete();
    end else begin
      model_out(byp, qi, fin, v, d);
      push = f_valid && (qi.size() != DEPTH);
      pop  = v && d_ready;
      if (!(byp && qi.size() == 0 && push && pop)) begin
        if (pop) void'(qo.pop_front());
        if (push) qo.push_back(fin);
      end
    end
  endfunction

  task automatic cmp_dut(input string n, input bit v, input fetch_entry_t d, input int sz,
                         input logic fr, input logic dv, input logic [IL-1:0] ins,
                         input logic [XL-1:0] pc, input logic [XL-1:0] npc,
                         input logic [CW-1:0] cnt, input logic af);
    check({n, "_valid"}, 64'(dv), 64'(v));
    check({n, "_pc"}, 64'(pc), 64'(d.current_pc));
    check({n, "_npc"}, 64'(npc), 64'(d.next_pc));
    check({n, "_instr"}, 64'(ins), 64'(d.instr));
    check({n, "_count"}, 64'(cnt), 64'(sz));
    check({n, "_ready"}, 64'(fr), 64'(sz != DEPTH));
    check({n, "_afull"}, 64'(af), 64'(sz >= DEPTH - 1));
  endtask

  // One clock: compare both DUTs at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    fetch_entry_t fin, db, dr;
    fetch_entry_t nb[$];
    fetch_entry_t nr[$];
    bit vb, vr;
    fin = '{instr: f_instr, current_pc: f_pc, next_pc: f_npc};
    @(negedge clk);
    if (model_ok) begin
      model_out(1'b1, qb, fin, vb, db);
      model_out(1'b0, qr, fin, vr, dr);
      cmp_dut("byp", vb, db, qb.size(), b_f_ready, b_d_valid, b_instr, b_pc, b_npc, b_count, b_af);
      cmp_dut("reg", vr, dr, qr.size(), r_f_ready, r_d_valid, r_instr, r_pc, r_npc, r_count, r_af);
      if (r_d_valid && d_ready && !flush && !rst) popped.push_back(r_pc);
    end
    @(posedge clk);
    model_step(1'b1, qb, fin, nb);
    model_step(1'b0, qr, fin, nr);
    qb = nb;
    qr = nr;
    if (rst) model_ok = 1'b1;
    #1;
  endtask

  task automatic offer(input logic [XL-1:0] pc, input logic rdy);
    f_valid = 1'b1;
    f_pc    = pc;
    f_npc   = pc + 32'h4;
    f_instr = IL'($urandom);
    d_ready = rdy;
  endtask

  task automatic idle(input logic rdy, input int n);
    f_valid = 1'b0;
    d_ready = rdy;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset and reset state
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("rst_count", 64'(r_count), 64'd0);
    check("rst_dvalid", 64'(r_d_valid), 64'd0);
    check("rst_fready", 64'(r_f_ready), 64'd1);
    check("rst_data", 64'(r_pc), 64'd0);
    idle(1'b0, 1);

    // Three pushes with decode stalled
    for (int i = 0; i < 3; i++) begin
      offer(XL'(4 * i), 1'b0);
      cycle();
    end
    f_valid = 1'b0;
    #1;
    check("p1_count", 64'(r_count), 64'd3);
    check("p1_afull", 64'(r_af), 64'd1);
    check("p1_fready", 64'(r_f_ready), 64'd1);
    check("p1_headpc", 64'(b_pc), 64'h0);

    // Fill, refuse while full, then accept after the pop
    offer(32'hC, 1'b0);
    cycle();
    popped.delete();
    offer(32'h10, 1'b1);
    #1;
    check("p2_full_ready", 64'(r_f_ready), 64'd0);
    cycle();
    check("p2_count_after_pop", 64'(r_count), 64'd3);
    check("p2_ready_again", 64'(r_f_ready), 64'd1);
    cycle();
    idle(1'b1, 4);
    check("p2_npops", 64'(popped.size()), 64'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      check("p2_order", 64'(popped[i]), 64'(4 * i));

    // Bypass versus registered path on an empty queue
    offer(32'h100, 1'b1);
    #1;
    check("p3_byp_valid", 64'(b_d_valid), 64'd1);
    check("p3_byp_pc", 64'(b_pc), 64'h100);
    check("p3_reg_valid", 64'(r_d_valid), 64'd0);
    cycle();
    f_valid = 1'b0;
    #1;
    check("p3_byp_count", 64'(b_count), 64'd0);
    check("p3_reg_valid_next", 64'(r_d_valid), 64'd1);
    check("p3_reg_pc_next", 64'(r_pc), 64'h100);
    idle(1'b1, 2);

    // Flush with a concurrent push
    for (int i = 0; i < 3; i++) begin
      offer(XL'(32'h20 + 4 * i), 1'b0);
      cycle();
    end
    offer(32'h200, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    f_valid = 1'b0;
    #1;
    check("p4_count", 64'(r_count), 64'd0);
    check("p4_dvalid", 64'(r_d_valid), 64'd0);
    popped.delete();
    idle(1'b1, 3);
    check("p4_no_emerge", 64'(popped.size()), 64'd0);

    // Randomised traffic across several pointer wraps
    for (int i = 0; i < 12 * DEPTH; i++) begin
      offer(XL'($urandom) & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
      f_valid = 1'($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      cycle();
    end
    flush = 1'b0;
    idle(1'b1, DEPTH + 1);

    // Reset mid-operation with a push offered
    offer(32'h40, 1'b0);
    cycle();
    offer(32'h44, 1'b0);
    cycle();
    check("p6_count_pre", 64'(r_count), 64'd2);
    offer(32'h48, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    f_valid = 1'b0;
    #1;
    check("p6_count", 64'(r_count), 64'd0);
    check("p6_dvalid", 64'(r_d_valid), 64'd0);
    check("p6_fready", 64'(r_f_ready), 64'd1);
    check("p6_byp_count", 64'(b_count), 64'd0);

    // Reset and flush together
    offer(32'h60, 1'b0);
    cycle();
    rst = 1'b1;
    flush = 1'b1;
    f_valid = 1'b0;
    cycle();
    rst = 1'b0;
    flush = 1'b0;
    idle(1'b1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
